// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix job cores.
//   mat_mode_t  : element operation select (wrap/saturating add/sub)
//   mat_state_t : start/busy/done job FSM states
//   MAT_SAT_MAX_64 : positive saturation bound source (supports WIDTH <= 64)
package mat_pkg;

    typedef enum logic [1:0] {
        MAT_ADD     = 2'b00,
        MAT_SUB     = 2'b01,
        MAT_ADD_SAT = 2'b10,
        MAT_SUB_SAT = 2'b11
    } mat_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mat_state_t;

    localparam int unsigned MAT_MAX_WIDTH  = 64;
    localparam logic [63:0] MAT_SAT_MAX_64 = 64'h7FFF_FFFF_FFFF_FFFF;

    // Mode decode helpers shared by all element-wise lanes.
    function automatic logic mode_is_sub(input mat_mode_t m);
        return (m == MAT_SUB) || (m == MAT_SUB_SAT);
    endfunction

    function automatic logic mode_is_sat(input mat_mode_t m);
        return (m == MAT_ADD_SAT) || (m == MAT_SUB_SAT);
    endfunction

endpackage

// File: rtl/mat_ew_lane.sv
// One combinational element lane: result = a op b on WIDTH-bit signed values.
//   a, b   : operands (two's complement)
//   mode   : operation
//   result : wrapped or clamped result
//   ovf    : result did not fit in WIDTH signed bits (wrapped or clamped)
module mat_ew_lane
    import mat_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mat_mode_t        mode,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(MAT_SAT_MAX_64 >> (MAT_MAX_WIDTH - WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] sum;

    // One guard bit: overflow shows as disagreement between the top two bits.
    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = {b[WIDTH-1], b};
    assign sum   = mode_is_sub(mode) ? (a_ext - b_ext) : (a_ext + b_ext);
    assign ovf   = sum[WIDTH] ^ sum[WIDTH-1];

    // Guard bit carries the true sign, so it picks the clamp direction.
    always_comb begin
        result = sum[WIDTH-1:0];
        if (mode_is_sat(mode) && ovf) begin
            result = sum[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/mat_ew_unit.sv
// Element-wise matrix engine C = A op B, LANES elements per beat.
//   clk, reset_n : clock, async active-low reset
//   start, mode  : job request and operation, sampled in IDLE
//   a_flat, b_flat : row-major operands, element k at [k*WIDTH +: WIDTH]
//   c_flat       : registered result, same layout
//   busy, done   : job handshake (done is a one-cycle pulse)
//   ovf          : sticky overflow/clamp flag for the last job
module mat_ew_unit
    import mat_pkg::*;
#(
    parameter int unsigned ROWS  = 3,
    parameter int unsigned COLS  = 3,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [ROWS*COLS*WIDTH-1:0]  a_flat,
    input  logic [ROWS*COLS*WIDTH-1:0]  b_flat,
    output logic [ROWS*COLS*WIDTH-1:0]  c_flat,
    output logic                        busy,
    output logic                        done,
    output logic                        ovf
);

    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned NW    = N * WIDTH;
    localparam int unsigned BEATS = (N + LANES - 1) / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned DW    = (NW > 1) ? $clog2(NW) : 1;

    mat_state_t      state;
    mat_mode_t       mode_q;
    logic [CW-1:0]   beat;
    logic [NW-1:0]   a_q;
    logic [NW-1:0]   b_q;

    logic [LANES-1:0] lane_v;
    logic [LANES-1:0] lane_o;
    logic [WIDTH-1:0] lane_r    [LANES];
    logic [DW-1:0]    lane_base [LANES];

    // Lane l of beat j handles element j*LANES+l; lanes past N are inert.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0]      k;
        logic [31:0]      k_safe;
        logic [WIDTH-1:0] la;
        logic [WIDTH-1:0] lb;

        assign k            = 32'(beat) * 32'(LANES) + 32'(l);
        assign lane_v[l]    = (k < 32'(N));
        assign k_safe       = lane_v[l] ? k : 32'd0;
        assign lane_base[l] = DW'(k_safe * 32'(WIDTH));
        assign la           = a_q[lane_base[l] +: WIDTH];
        assign lb           = b_q[lane_base[l] +: WIDTH];

        mat_ew_lane #(.WIDTH(WIDTH)) u_lane (
            .a      (la),
            .b      (lb),
            .mode   (mode_q),
            .result (lane_r[l]),
            .ovf    (lane_o[l])
        );
    end

    // Job FSM, operand snapshot and result write-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            mode_q <= MAT_ADD;
            beat   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_flat <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a_flat;
                        b_q    <= b_flat;
                        mode_q <= mat_mode_t'(mode);
                        ovf    <= 1'b0;
                        beat   <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_v[l]) begin
                            c_flat[lane_base[l] +: WIDTH] <= lane_r[l];
                        end
                    end
                    ovf <= ovf | (|(lane_v & lane_o));
                    if (32'(beat) == BEATS - 1) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        beat <= beat + CW'(1);
                    end
                end
                ST_DONE: begin
                    // First DONE cycle raises the pulse, the second retires it.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    a_beat_range: assert property (@(posedge clk) disable iff (!reset_n)
        (state == ST_RUN) |-> (32'(beat) < BEATS));

endmodule

// File: tb/tb_mat_ew_unit.sv
module tb_mat_ew_unit;

    localparam int W  = 32;
    localparam int N  = 9;
    localparam int NW = N * W;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_c;
        logic         exp_ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start1, start4;
    logic [1:0]    mode;
    logic [NW-1:0] a_flat, b_flat;
    logic [NW-1:0] c1, c4;
    logic          busy1, busy4, done1, done4, ovf1, ovf4;

    int which;
    int n_cmp  = 0;
    int n_fail = 0;

    wire [NW-1:0] c_m    = (which != 0) ? c4 : c1;
    wire          busy_m = (which != 0) ? busy4 : busy1;
    wire          done_m = (which != 0) ? done4 : done1;
    wire          ovf_m  = (which != 0) ? ovf4 : ovf1;

    always #5 clk = ~clk;

    mat_ew_unit #(.ROWS(3), .COLS(3), .WIDTH(W), .LANES(1)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c1),
        .busy(busy1), .done(done1), .ovf(ovf1)
    );

    mat_ew_unit #(.ROWS(3), .COLS(3), .WIDTH(W), .LANES(4)) u4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .mode(mode),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c4),
        .busy(busy4), .done(done4), .ovf(ovf4)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (which != 0) start4 = v;
        else            start1 = v;
    endtask

    task automatic set_all(input logic [W-1:0] av, input logic [W-1:0] bv);
        for (int k = 0; k < N; k++) begin
            a_flat[k*W +: W] = av;
            b_flat[k*W +: W] = bv;
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N; k++) begin
            a_flat[k*W +: W] = W'(k + 1);
            b_flat[k*W +: W] = W'(10 * (k + 1));
        end
    endtask

    task automatic check_ramp(input string nm);
        for (int k = 0; k < N; k++)
            check(nm, 64'(c_m[k*W +: W]), 64'(11 * (k + 1)));
    endtask

    // Pulse start, then count edges to done (0 on timeout) and busy-high samples.
    task automatic run_job(output int lat, output int bcnt);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        lat  = 0;
        bcnt = busy_m ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done_m) begin
                lat = i;
                break;
            end
            if (busy_m) bcnt++;
        end
    endtask

    vec_t vecs [9];
    int   lat, bcnt, dones, first_done;

    initial begin
        vecs[0] = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[1] = '{2'b10, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        vecs[2] = '{2'b11, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[3] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[5] = '{2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        vecs[6] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[7] = '{2'b01, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
        vecs[8] = '{2'b10, 32'h0000_000A, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0};

        which   = 0;
        reset_n = 1'b0;
        start1  = 1'b0;
        start4  = 1'b0;
        mode    = 2'b00;
        a_flat  = '0;
        b_flat  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_done1", 64'(done1), 64'd0);
        check("rst_ovf1",  64'(ovf1),  64'd0);
        check("rst_c1",    64'($countones(c1)), 64'd0);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_c4",    64'($countones(c4)), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Ramp ADD on the single-lane unit.
        which = 0;
        mode  = 2'b00;
        set_ramp();
        run_job(lat, bcnt);
        check("ramp_lat",  64'(lat),  64'd10);
        check("ramp_busy", 64'(bcnt), 64'd9);
        check("ramp_ovf",  64'(ovf_m), 64'd0);
        check_ramp("ramp_c");
        @(posedge clk); #1;
        check("ramp_done_pulse", 64'(done_m), 64'd0);

        // Table vectors on both lane configurations.
        for (int d = 0; d < 2; d++) begin
            which = d;
            for (int v = 0; v < 9; v++) begin
                mode = vecs[v].mode;
                set_all(vecs[v].a, vecs[v].b);
                run_job(lat, bcnt);
                check($sformatf("vec%0d_d%0d_lat", v, d), 64'(lat), (d != 0) ? 64'd4 : 64'd10);
                check($sformatf("vec%0d_d%0d_busy", v, d), 64'(bcnt), (d != 0) ? 64'd3 : 64'd9);
                check($sformatf("vec%0d_d%0d_ovf", v, d), 64'(ovf_m), 64'(vecs[v].exp_ovf));
                for (int k = 0; k < N; k++)
                    check($sformatf("vec%0d_d%0d_c%0d", v, d, k), 64'(c_m[k*W +: W]), 64'(vecs[v].exp_c));
                @(posedge clk); #1;
            end
        end

        // Overflow only in element 0 must still set the sticky flag.
        which = 0;
        mode  = 2'b00;
        set_all(32'd1, 32'd1);
        a_flat[0 +: W] = 32'h7FFF_FFFF;
        run_job(lat, bcnt);
        check("e0_c0",  64'(c_m[0 +: W]), 64'h8000_0000);
        check("e0_c8",  64'(c_m[8*W +: W]), 64'd2);
        check("e0_ovf", 64'(ovf_m), 64'd1);
        @(posedge clk); #1;

        // Mid-run restart and operand/mode changes are ignored.
        which = 0;
        mode  = 2'b00;
        set_ramp();
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        repeat (2) begin @(posedge clk); #1; end
        set_start(1'b1);
        mode = 2'b01;
        set_all(32'd1000, 32'd1);
        @(posedge clk); #1;
        set_start(1'b0);
        dones      = 0;
        first_done = 0;
        for (int i = 4; i <= 25; i++) begin
            @(posedge clk); #1;
            if (done_m) begin
                dones++;
                if (first_done == 0) first_done = i;
                if (dones == 1) check_ramp("hs_c");
            end
        end
        check("hs_dones",   64'(dones), 64'd1);
        check("hs_lat",     64'(first_done), 64'd10);
        check("hs_ovf",     64'(ovf_m), 64'd0);
        check("hs_idle",    64'(busy_m), 64'd0);

        // Overflowing job, then a clean job clears ovf at acceptance.
        mode = 2'b00;
        set_all(32'h7FFF_FFFF, 32'd1);
        run_job(lat, bcnt);
        check("ovf_set", 64'(ovf_m), 64'd1);
        @(posedge clk); #1;
        set_ramp();
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        check("ovf_clr_accept", 64'(ovf_m), 64'd0);
        check("busy_accept",    64'(busy_m), 64'd1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done_m) begin lat = i; break; end
        end
        check("post_lat", 64'(lat), 64'd10);
        check_ramp("post_c");
        @(posedge clk); #1;

        // Asynchronous reset during beat 3 aborts the job.
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy1), 64'd0);
        check("mid_rst_done", 64'(done1), 64'd0);
        check("mid_rst_ovf",  64'(ovf1),  64'd0);
        check("mid_rst_c",    64'($countones(c1)), 64'd0);
        dones = 0;
        repeat (3) begin @(posedge clk); #1; if (done1) dones++; end
        check("mid_rst_nodone", 64'(dones), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        set_ramp();
        mode = 2'b00;
        run_job(lat, bcnt);
        check("after_rst_lat",  64'(lat),  64'd10);
        check("after_rst_busy", 64'(bcnt), 64'd9);
        check_ramp("after_rst_c");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
